// File: rtl/vga_timing_pkg.sv
// Shared game package: 640x480@60 timing defaults and colour codes used by
// the VGA timing generator and every drawing block.
package vga_timing_pkg;

    localparam int unsigned DefClkDiv  = 2;

    localparam int unsigned DefHVisible = 640;
    localparam int unsigned DefHFront   = 16;
    localparam int unsigned DefHSync    = 96;
    localparam int unsigned DefHBack    = 48;
    localparam int unsigned DefVVisible = 480;
    localparam int unsigned DefVFront   = 10;
    localparam int unsigned DefVSync    = 2;
    localparam int unsigned DefVBack    = 33;

    typedef enum logic [2:0] {
        ColBackground = 3'd0,
        ColSpaceship  = 3'd1,
        ColAlien0     = 3'd2,
        ColAlien1     = 3'd3,
        ColAlien2     = 3'd4,
        ColAlien3     = 3'd5,
        ColLaser      = 3'd6,
        ColNone       = 3'd7
    } color_e;

    // Inclusive 10-bit window test, used for the sync pulses.
    function automatic logic in_window(input logic [9:0] pos, input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (pos >= lo) && (pos <= hi);
    endfunction

endpackage

// File: rtl/vga_palette.sv
// Colour code to RRRGGGBB lookup, purely combinational.
module vga_palette
    import vga_timing_pkg::*;
(
    input  logic [2:0] code,
    output logic [7:0] rgb
);

    always_comb begin
        rgb = 8'h00;
        unique case (color_e'(code))
            ColBackground: rgb = 8'h00;
            ColSpaceship:  rgb = 8'h1C;
            ColAlien0:     rgb = 8'hE0;
            ColAlien1:     rgb = 8'hFC;
            ColAlien2:     rgb = 8'hE3;
            ColAlien3:     rgb = 8'h1F;
            ColLaser:      rgb = 8'hFF;
            ColNone:       rgb = 8'h00;
        endcase
    end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: pixel-rate divider, h/v position counters and registered
// sync/colour outputs aligned one pixel tick behind the counters.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DefClkDiv,
    parameter int unsigned H_VISIBLE = DefHVisible,
    parameter int unsigned H_FRONT   = DefHFront,
    parameter int unsigned H_SYNC    = DefHSync,
    parameter int unsigned H_BACK    = DefHBack,
    parameter int unsigned V_VISIBLE = DefVVisible,
    parameter int unsigned V_FRONT   = DefVFront,
    parameter int unsigned V_SYNC    = DefVSync,
    parameter int unsigned V_BACK    = DefVBack
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] color,
    output logic [9:0] hPos,
    output logic [9:0] vPos,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] rgb,
    output logic       frame_start
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

    localparam logic [9:0] HMax     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] VMax     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] HVisLim  = 10'(H_VISIBLE);
    localparam logic [9:0] VVisLim  = 10'(V_VISIBLE);
    localparam logic [9:0] HSyncLo  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HSyncHi  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VSyncLo  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VSyncHi  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [DivW-1:0] div_q, div_d;
    logic [9:0]      hpos_q, hpos_d;
    logic [9:0]      vpos_q, vpos_d;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic [7:0]      rgb_q, rgb_d;
    logic            fs_q, fs_d;
    logic [7:0]      pal_rgb;
    logic            tick, h_wrap, v_wrap, video_on;

    vga_palette u_palette (
        .code (color),
        .rgb  (pal_rgb)
    );

    always_comb begin
        tick     = (div_q == DivMax);
        h_wrap   = (hpos_q == HMax);
        v_wrap   = (vpos_q == VMax);
        video_on = (hpos_q < HVisLim) && (vpos_q < VVisLim);

        div_d   = tick ? '0 : div_q + 1'b1;
        hpos_d  = hpos_q;
        vpos_d  = vpos_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        rgb_d   = rgb_q;
        fs_d    = 1'b0;

        // Outputs are sampled from the position before it advances, which
        // gives the one-tick latency and keeps rgb and both syncs aligned.
        if (tick) begin
            hpos_d  = h_wrap ? 10'd0 : hpos_q + 10'd1;
            if (h_wrap) begin
                vpos_d = v_wrap ? 10'd0 : vpos_q + 10'd1;
            end
            hsync_d = !in_window(hpos_q, HSyncLo, HSyncHi);
            vsync_d = !in_window(vpos_q, VSyncLo, VSyncHi);
            rgb_d   = video_on ? pal_rgb : 8'h00;
            fs_d    = h_wrap && v_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q   <= '0;
            hpos_q  <= 10'd0;
            vpos_q  <= 10'd0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= 8'h00;
            fs_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
            fs_q    <= fs_d;
        end
    end

    assign hPos        = hpos_q;
    assign vPos        = vpos_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb         = rgb_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a reduced-geometry instance (full frames fit in a short
// run) and a default instance, both checked every clk against a tick-count model.
module tb_vga_timing;

    localparam int ClkDiv = 2;
    localparam int SHV = 40, SHF = 4, SHS = 8, SHB = 6;
    localparam int SVV = 20, SVF = 2, SVS = 2, SVB = 3;
    localparam int SHTot = SHV + SHF + SHS + SHB;
    localparam int SVTot = SVV + SVF + SVS + SVB;
    localparam int SFrameClks = SHTot * SVTot * ClkDiv;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] color;

    logic [9:0] s_h, s_v, d_h, d_v;
    logic       s_hs, s_vs, s_fs, d_hs, d_vs, d_fs;
    logic [7:0] s_rgb, d_rgb;

    int n_checks = 0;
    int n_fail   = 0;
    int fs_count, hmax, vmax, guard;

    logic [7:0] pal [8];

    typedef struct {
        int         hvis, hfp, hsw, hbp, vvis, vfp, vsw, vbp;
        int         cyc, ticks;
        logic       hsync, vsync, fs;
        logic [7:0] rgb;
    } model_t;

    model_t ms, md;

    vga_timing #(
        .H_VISIBLE (SHV), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
        .V_VISIBLE (SVV), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB)
    ) u_dut_small (
        .clk         (clk),
        .reset       (reset),
        .color       (color),
        .hPos        (s_h),
        .vPos        (s_v),
        .hsync       (s_hs),
        .vsync       (s_vs),
        .rgb         (s_rgb),
        .frame_start (s_fs)
    );

    vga_timing u_dut_dflt (
        .clk         (clk),
        .reset       (reset),
        .color       (color),
        .hPos        (d_h),
        .vPos        (d_v),
        .hsync       (d_hs),
        .vsync       (d_vs),
        .rgb         (d_rgb),
        .frame_start (d_fs)
    );

    always #5 clk = ~clk;

    function automatic model_t geom(input int hv, hf, hs, hb, vv, vf, vs, vb);
        model_t m;
        m.hvis = hv; m.hfp = hf; m.hsw = hs; m.hbp = hb;
        m.vvis = vv; m.vfp = vf; m.vsw = vs; m.vbp = vb;
        m.cyc = 0; m.ticks = 0;
        m.hsync = 1'b1; m.vsync = 1'b1; m.fs = 1'b0; m.rgb = 8'h00;
        return m;
    endfunction

    function automatic int htot(input model_t m);
        return m.hvis + m.hfp + m.hsw + m.hbp;
    endfunction

    function automatic int vtot(input model_t m);
        return m.vvis + m.vfp + m.vsw + m.vbp;
    endfunction

    // Advance one clk edge: position is just the tick count folded into the raster.
    function automatic model_t model_step(input model_t m, input logic rst_n,
                                          input logic [2:0] col);
        int h, v, ht, vt;
        ht = htot(m);
        vt = vtot(m);
        if (!rst_n) begin
            m.cyc = 0; m.ticks = 0;
            m.hsync = 1'b1; m.vsync = 1'b1; m.rgb = 8'h00; m.fs = 1'b0;
        end else begin
            m.cyc++;
            m.fs = 1'b0;
            if (m.cyc % ClkDiv == 0) begin
                h = m.ticks % ht;
                v = (m.ticks / ht) % vt;
                m.hsync = !(h >= m.hvis + m.hfp && h < m.hvis + m.hfp + m.hsw);
                m.vsync = !(v >= m.vvis + m.vfp && v < m.vvis + m.vfp + m.vsw);
                m.rgb   = (h < m.hvis && v < m.vvis) ? pal[col] : 8'h00;
                m.ticks++;
                m.fs    = (m.ticks % (ht * vt)) == 0;
            end
        end
        return m;
    endfunction

    function automatic logic [30:0] model_vec(input model_t m);
        return {10'(m.ticks % htot(m)), 10'((m.ticks / htot(m)) % vtot(m)),
                m.hsync, m.vsync, m.rgb, m.fs};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [2:0] pick(input int mode, input int k);
        case (mode)
            0:       return 3'($urandom_range(0, 7));
            1:       return 3'd1;
            2:       return 3'd6;
            default: return (k % 2 != 0) ? 3'd1 : 3'd2;
        endcase
    endfunction

    task automatic step(input logic rst_v, input logic [2:0] col_v);
        reset = rst_v;
        color = col_v;
        @(posedge clk);
        ms = model_step(ms, rst_v, col_v);
        md = model_step(md, rst_v, col_v);
        @(negedge clk);
        check_eq("small", {1'b0, s_h, s_v, s_hs, s_vs, s_rgb, s_fs}, {1'b0, model_vec(ms)});
        check_eq("dflt", {1'b0, d_h, d_v, d_hs, d_vs, d_rgb, d_fs}, {1'b0, model_vec(md)});
        if (s_fs) fs_count++;
        if (int'(s_h) > hmax) hmax = int'(s_h);
        if (int'(s_v) > vmax) vmax = int'(s_v);
    endtask

    initial begin
        pal = '{8'h00, 8'h1C, 8'hE0, 8'hFC, 8'hE3, 8'h1F, 8'hFF, 8'h00};
        ms  = geom(SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
        md  = geom(640, 16, 96, 48, 480, 10, 2, 33);
        reset = 1'b0;
        color = 3'd0;
        fs_count = 0; hmax = 0; vmax = 0;

        repeat (3) step(1'b0, 3'($urandom_range(0, 7)));
        check_eq("rst_state", {1'b0, s_h, s_v, s_hs, s_vs, s_rgb, s_fs},
                 {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 8'h00, 1'b0});

        // Two uninterrupted frames, colour mode rotating every five lines.
        fs_count = 0; hmax = 0; vmax = 0;
        for (int k = 0; k < 2 * SFrameClks; k++) begin
            step(1'b1, pick((k / (SHTot * ClkDiv * 5)) % 4, k));
        end
        check_eq("frame_pulses", 32'(fs_count), 32'd2);
        check_eq("hpos_max", 32'(hmax), 32'(SHTot - 1));
        check_eq("vpos_max", 32'(vmax), 32'(SVTot - 1));

        // Random colour with occasional short resets.
        for (int k = 0; k < 6000; k++) begin
            if ($urandom_range(0, 1499) == 0) begin
                repeat ($urandom_range(1, 3)) step(1'b0, pick(0, k));
            end else begin
                step(1'b1, pick((k / 300) % 4, k));
            end
        end

        // Mid-frame reset at a known position.
        guard = 0;
        while (!((ms.ticks % SHTot) == 30 && ((ms.ticks / SHTot) % SVTot) == 10)
               && guard < 2 * SFrameClks) begin
            step(1'b1, pick(0, guard));
            guard++;
        end
        check_eq("reach_pos", {12'd0, s_h, s_v}, {12'd0, 10'd30, 10'd10});
        step(1'b0, 3'd6);
        check_eq("rst_mid", {1'b0, s_h, s_v, s_hs, s_vs, s_rgb, s_fs},
                 {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 8'h00, 1'b0});
        step(1'b1, 3'd1);
        check_eq("no_early_tick", 32'(s_h), 32'd0);
        step(1'b1, 3'd1);
        check_eq("first_tick", 32'(s_h), 32'd1);
        check_eq("first_rgb", 32'(s_rgb), 32'h1C);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
